// File: rtl/bubble_pkg.sv
// Shared types, control-vector layout and default timing for the bubble read path.
// The control decode lives here so reader and timing tests agree on which line is active.
package bubble_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEEK  = 3'd2,
    REPL  = 3'd3,
    XFER  = 3'd4,
    STOP  = 3'd5
  } state_e;

  localparam int CTL_W      = 5;
  localparam int CTL_BSS    = 0;
  localparam int CTL_BSEN   = 1;
  localparam int CTL_REPEN  = 2;
  localparam int CTL_BOOTEN = 3;
  localparam int CTL_SWAPEN = 4;
  localparam logic [CTL_W-1:0] CTL_IDLE = 5'b11111;

  localparam int DEF_BITCYC     = 480;
  localparam int DEF_SAMPLEOFS  = 240;
  localparam int DEF_STARTSLOTS = 4;
  localparam int DEF_SEEKOFS    = 20;
  localparam int DEF_PAGEBITS   = 512;
  localparam int DEF_NPAGES     = 2053;
  localparam int DEF_STOPSLOTS  = 4;
  localparam int SLOT_W         = 13;

  // Active-low control lines for a given state; the swap line is never driven.
  function automatic logic [CTL_W-1:0] ctl_decode(input state_e st, input logic boot);
    logic [CTL_W-1:0] c;
    c = CTL_IDLE;
    case (st)
      START:      c[CTL_BSS]  = 1'b0;
      SEEK, XFER: c[CTL_BSEN] = 1'b0;
      REPL: begin
        c[CTL_BSEN]  = 1'b0;
        c[CTL_REPEN] = 1'b0;
      end
      default:    c = CTL_IDLE;
    endcase
    if (boot && (st inside {START, SEEK, REPL, XFER})) begin
      c[CTL_BOOTEN] = 1'b0;
    end else begin
      c[CTL_BOOTEN] = 1'b1;
    end
    c[CTL_SWAPEN] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/bubble_slot_timer.sv
// Bit-slot cycle counter: flags the last cycle of a slot and the DIN sample cycle.
module bubble_slot_timer #(
  parameter int BITCYC    = 480,
  parameter int SAMPLEOFS = 240
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_s,
  output logic slot_end_s,
  output logic sample_s
);

  localparam int CW = (BITCYC > 1) ? $clog2(BITCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITCYC - 1);
  localparam logic [CW-1:0] SMP  = CW'(SAMPLEOFS);

  logic [CW-1:0] cnt_r;

  // Free-running slot counter, restarted on command accept and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr_s) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign slot_end_s = (cnt_r == LAST);
  assign sample_s   = (cnt_r == SMP);

endmodule

// File: rtl/bubble_page_reader.sv
// Host-side bubble read initiator: sequences the control lines per slot and
// assembles sampled DOUT bits into bytes behind a single holding register.
module bubble_page_reader
  import bubble_pkg::*;
#(
  parameter int BITCYC     = DEF_BITCYC,
  parameter int SAMPLEOFS  = DEF_SAMPLEOFS,
  parameter int STARTSLOTS = DEF_STARTSLOTS,
  parameter int SEEKOFS    = DEF_SEEKOFS,
  parameter int PAGEBITS   = DEF_PAGEBITS,
  parameter int NPAGES     = DEF_NPAGES,
  parameter int STOPSLOTS  = DEF_STOPSLOTS
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_BOOT,
  input  logic [11:0] CMD_PAGE,
  input  logic        BITWIDTH4,
  input  logic        ABORT,
  input  logic [3:0]  DIN,
  output logic        nBSS,
  output logic        nBSEN,
  output logic        nREPEN,
  output logic        nBOOTEN,
  output logic        nSWAPEN,
  output logic [7:0]  RD_DATA,
  output logic        RD_VALID,
  input  logic        RD_READY,
  output logic        BUSY,
  output logic        CMD_ERR,
  output logic        OVERRUN
);

  localparam logic [SLOT_W-1:0] START_LAST = SLOT_W'(STARTSLOTS - 1);
  localparam logic [SLOT_W-1:0] STOP_LAST  = SLOT_W'(STOPSLOTS - 1);
  localparam logic [SLOT_W-1:0] XFER1_LAST = SLOT_W'(PAGEBITS - 1);
  localparam logic [SLOT_W-1:0] XFER4_LAST = SLOT_W'(PAGEBITS / 4 - 1);

  state_e             state_r, state_nxt_s;
  logic               boot_r, boot_nxt_s, w4_r;
  logic [SLOT_W-1:0]  seek_last_r, idx_r, xfer_last_s;
  logic [3:0]         din_meta_r, din_sync_r;
  logic [7:0]         sh_r, sh_nxt_s, rd_data_r;
  logic [2:0]         bcnt_r;
  logic [CTL_W-1:0]   ctl_r;
  logic               cmd_ready_r, busy_r, cmd_err_r, rd_valid_r, overrun_r;
  logic               accept_s, reject_s, abort_s, timer_clr_s;
  logic               slot_end_s, sample_s, sample_xfer_s, byte_done_s;

  bubble_slot_timer #(.BITCYC(BITCYC), .SAMPLEOFS(SAMPLEOFS)) u_timer (
    .clk        (MCLK),
    .rst_n      (nRESET),
    .clr_s      (timer_clr_s),
    .slot_end_s (slot_end_s),
    .sample_s   (sample_s)
  );

  assign accept_s      = CMD_VALID && (state_r == IDLE);
  assign reject_s      = accept_s && !CMD_BOOT && ({1'b0, CMD_PAGE} >= SLOT_W'(NPAGES));
  assign abort_s       = ABORT && (state_r inside {START, SEEK, REPL, XFER});
  assign xfer_last_s   = w4_r ? XFER4_LAST : XFER1_LAST;
  assign sample_xfer_s = sample_s && (state_r == XFER) && !abort_s;
  assign sh_nxt_s      = w4_r ? {din_sync_r, sh_r[7:4]} : {din_sync_r[0], sh_r[7:1]};
  assign byte_done_s   = sample_xfer_s && (bcnt_r == (w4_r ? 3'd1 : 3'd7));

  // Next-state decode; abort takes priority and restarts slot timing for STOP.
  always_comb begin
    state_nxt_s = state_r;
    boot_nxt_s  = boot_r;
    timer_clr_s = 1'b0;
    if (abort_s) begin
      state_nxt_s = STOP;
      timer_clr_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && !reject_s) begin
            state_nxt_s = START;
            boot_nxt_s  = CMD_BOOT;
            timer_clr_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        START: if (slot_end_s && (idx_r == START_LAST)) state_nxt_s = SEEK; else state_nxt_s = START;
        SEEK:  if (slot_end_s && (idx_r == seek_last_r)) state_nxt_s = REPL; else state_nxt_s = SEEK;
        REPL:  if (slot_end_s) state_nxt_s = XFER; else state_nxt_s = REPL;
        XFER:  if (slot_end_s && (idx_r == xfer_last_s)) state_nxt_s = STOP; else state_nxt_s = XFER;
        STOP:  if (slot_end_s && (idx_r == STOP_LAST)) state_nxt_s = IDLE; else state_nxt_s = STOP;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Two-flop DIN synchronizer.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      din_meta_r <= 4'h0;
      din_sync_r <= 4'h0;
    end else begin
      din_meta_r <= DIN;
      din_sync_r <= din_meta_r;
    end
  end

  // Sequencer state, latched command and registered control/status outputs.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r     <= IDLE;
      boot_r      <= 1'b0;
      w4_r        <= 1'b0;
      seek_last_r <= '0;
      idx_r       <= '0;
      ctl_r       <= CTL_IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      cmd_err_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      boot_r    <= boot_nxt_s;
      cmd_err_r <= reject_s;
      if (accept_s && !reject_s) begin
        w4_r        <= BITWIDTH4;
        seek_last_r <= SLOT_W'(SEEKOFS) + (CMD_BOOT ? '0 : {1'b0, CMD_PAGE}) - SLOT_W'(1);
      end else begin
        w4_r        <= w4_r;
        seek_last_r <= seek_last_r;
      end
      if ((state_nxt_s != state_r) || (state_r == IDLE)) begin
        idx_r <= '0;
      end else if (slot_end_s) begin
        idx_r <= idx_r + SLOT_W'(1);
      end else begin
        idx_r <= idx_r;
      end
      ctl_r       <= ctl_decode(state_nxt_s, boot_nxt_s);
      cmd_ready_r <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Byte assembly, LSB first; a partial byte is dropped on accept or abort.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      sh_r   <= 8'h00;
      bcnt_r <= 3'd0;
    end else if (timer_clr_s) begin
      sh_r   <= 8'h00;
      bcnt_r <= 3'd0;
    end else if (sample_xfer_s) begin
      sh_r   <= sh_nxt_s;
      bcnt_r <= byte_done_s ? 3'd0 : bcnt_r + 3'd1;
    end else begin
      sh_r   <= sh_r;
      bcnt_r <= bcnt_r;
    end
  end

  // Output holding register; a completed byte with nowhere to go sets sticky overrun.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (byte_done_s) begin
      if (!rd_valid_r || RD_READY) begin
        rd_data_r  <= sh_nxt_s;
        rd_valid_r <= 1'b1;
      end else begin
        overrun_r  <= 1'b1;
      end
    end else if (rd_valid_r && RD_READY) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_valid_r;
    end
  end

  assign CMD_READY = cmd_ready_r;
  assign BUSY      = busy_r;
  assign CMD_ERR   = cmd_err_r;
  assign RD_DATA   = rd_data_r;
  assign RD_VALID  = rd_valid_r;
  assign OVERRUN   = overrun_r;
  assign nBSS      = ctl_r[CTL_BSS];
  assign nBSEN     = ctl_r[CTL_BSEN];
  assign nREPEN    = ctl_r[CTL_REPEN];
  assign nBOOTEN   = ctl_r[CTL_BOOTEN];
  assign nSWAPEN   = ctl_r[CTL_SWAPEN];

endmodule

// File: tb/tb_bubble_page_reader.sv
// Directed bench for bubble_page_reader with a shortened bit slot; DIN is driven per
// XFER slot and expected bytes are queued at stimulus time, then matched to delivered bytes.
module tb_bubble_page_reader;

  localparam int BITCYC    = 8;
  localparam int SAMPLEOFS = 4;

  logic        MCLK, nRESET, CMD_VALID, CMD_READY, CMD_BOOT, BITWIDTH4, ABORT;
  logic [11:0] CMD_PAGE;
  logic [3:0]  DIN;
  logic        nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN;
  logic [7:0]  RD_DATA;
  logic        RD_VALID, RD_READY, BUSY, CMD_ERR, OVERRUN;

  int n_vec = 0;
  int n_err = 0;
  int din_mode = 0;
  bit sb_en = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int cnt_bss = 0, cnt_bsen = 0, cnt_repen = 0, cnt_booten = 0, cnt_swap = 0, cnt_busy = 0, cnt_err = 0;
  int b_bss, b_bsen, b_repen, b_booten, b_swap, b_busy, b_err;
  bit xact = 1'b0;
  int xslot = 0;
  int xcyc = 0;

  bubble_page_reader #(.BITCYC(BITCYC), .SAMPLEOFS(SAMPLEOFS)) dut (
    .MCLK(MCLK), .nRESET(nRESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_BOOT(CMD_BOOT), .CMD_PAGE(CMD_PAGE), .BITWIDTH4(BITWIDTH4), .ABORT(ABORT),
    .DIN(DIN), .nBSS(nBSS), .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN),
    .nSWAPEN(nSWAPEN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR), .OVERRUN(OVERRUN)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  function automatic logic [4:0] ctl_now();
    return {nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // DIN pattern for XFER slot s; the expected byte is queued on the slot that completes it.
  task automatic drive_slot(input int s);
    logic [7:0] pat;
    logic [3:0] sv, pv;
    logic b;
    pat = 8'h0D;
    sv  = s[3:0];
    pv  = sv - 4'd1;
    case (din_mode)
      0: begin
        b   = pat[s % 8];
        DIN = {{3{~b}}, b};
        if (sb_en && (s % 8 == 7)) exp_q.push_back(8'h0D);
      end
      1: begin
        DIN = s[0] ? 4'h5 : 4'hA;
        if (sb_en && s[0]) exp_q.push_back(8'h5A);
      end
      default: begin
        DIN = sv;
        if (sb_en && s[0]) exp_q.push_back({sv, pv});
      end
    endcase
  endtask

  // Slot-aligned DIN driver, synchronised to the REPL -> XFER control edge.
  initial begin : din_drv
    logic prev_repen;
    prev_repen = 1'b1;
    DIN = 4'h0;
    forever begin
      @(posedge MCLK);
      #1;
      if (xact && nBSEN) begin
        xact = 1'b0;
      end else if (xact) begin
        xcyc++;
        if (xcyc == BITCYC) begin
          xcyc = 0;
          xslot++;
          drive_slot(xslot);
        end
      end else if (!prev_repen && nREPEN && !nBSEN) begin
        xact  = 1'b1;
        xcyc  = 0;
        xslot = 0;
        drive_slot(0);
      end
      prev_repen = nREPEN;
    end
  end

  // Output monitor: control low-time counters and delivered bytes.
  initial begin : mon
    forever begin
      @(negedge MCLK);
      if (!nBSS)    cnt_bss++;
      if (!nBSEN)   cnt_bsen++;
      if (!nREPEN)  cnt_repen++;
      if (!nBOOTEN) cnt_booten++;
      if (!nSWAPEN) cnt_swap++;
      if (BUSY)     cnt_busy++;
      if (CMD_ERR)  cnt_err++;
      if (sb_en && RD_VALID && RD_READY) got_q.push_back(RD_DATA);
    end
  end

  task automatic snap();
    b_bss = cnt_bss; b_bsen = cnt_bsen; b_repen = cnt_repen; b_booten = cnt_booten;
    b_swap = cnt_swap; b_busy = cnt_busy; b_err = cnt_err;
  endtask

  task automatic send(input logic boot, input logic [11:0] page, input logic w4);
    CMD_VALID = 1'b1; CMD_BOOT = boot; CMD_PAGE = page; BITWIDTH4 = w4;
    tick();
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n < budget), 1);
  endtask

  task automatic sb_check(input string tag, input int nbytes);
    chk({tag, "_nbytes"}, got_q.size(), nbytes);
    chk({tag, "_nexp"}, exp_q.size(), nbytes);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, ctl_now(), 5'h1F);
    chk({tag, "_ready"}, CMD_READY, 1'b1);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_valid"}, RD_VALID, 1'b0);
    chk({tag, "_data"}, RD_DATA, 8'h00);
    chk({tag, "_err"}, CMD_ERR, 1'b0);
    chk({tag, "_ovr"}, OVERRUN, 1'b0);
  endtask

  initial begin : main
    int n;
    nRESET = 1'b0; CMD_VALID = 1'b0; CMD_BOOT = 1'b0; CMD_PAGE = 12'd0;
    BITWIDTH4 = 1'b0; ABORT = 1'b0; RD_READY = 1'b1;
    repeat (3) tick();
    nRESET = 1'b1;
    @(negedge MCLK);
    chk_reset_vals("rst");

    // Out-of-range page: one error pulse, nothing starts.
    tick();
    snap();
    send(1'b0, 12'd2053, 1'b0);
    @(negedge MCLK);
    chk("rej_err", CMD_ERR, 1'b1);
    chk("rej_busy", BUSY, 1'b0);
    chk("rej_ctl", ctl_now(), 5'h1F);
    tick();
    @(negedge MCLK);
    chk("rej_err_pulse", cnt_err - b_err, 1);
    chk("rej_busy_cnt", cnt_busy - b_busy, 0);

    // Last valid page is accepted; abort during SEEK gives exactly the stop slots.
    tick();
    send(1'b0, 12'd2052, 1'b0);
    repeat (60) tick();
    @(negedge MCLK);
    chk("p2052_busy", BUSY, 1'b1);
    chk("p2052_seek", ctl_now(), 5'b10111);
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    snap();
    @(negedge MCLK);
    chk("abseek_ctl", ctl_now(), 5'h1F);
    wait_idle(200);
    chk("abseek_stop", cnt_busy - b_busy, 4 * BITCYC);

    // Boot read, 1-bit lanes; page field ignored.
    din_mode = 0;
    snap();
    send(1'b1, 12'hFFF, 1'b0);
    wait_idle(6000);
    chk("boot_bss", cnt_bss - b_bss, 4 * BITCYC);
    chk("boot_bsen", cnt_bsen - b_bsen, (20 + 1 + 512) * BITCYC);
    chk("boot_repen", cnt_repen - b_repen, BITCYC);
    chk("boot_booten", cnt_booten - b_booten, (4 + 20 + 1 + 512) * BITCYC);
    chk("boot_busy", cnt_busy - b_busy, (4 + 20 + 1 + 512 + 4) * BITCYC);
    chk("boot_swap", cnt_swap - b_swap, 0);
    sb_check("boot", 64);

    // Page 5, 4-bit lanes; a command presented while busy must be ignored.
    din_mode = 1;
    snap();
    send(1'b0, 12'd5, 1'b1);
    repeat (10) tick();
    CMD_VALID = 1'b1; CMD_BOOT = 1'b1; CMD_PAGE = 12'd7;
    tick();
    CMD_VALID = 1'b0;
    wait_idle(3000);
    chk("p5_bss", cnt_bss - b_bss, 4 * BITCYC);
    chk("p5_bsen", cnt_bsen - b_bsen, (25 + 1 + 128) * BITCYC);
    chk("p5_repen", cnt_repen - b_repen, BITCYC);
    chk("p5_booten", cnt_booten - b_booten, 0);
    chk("p5_busy", cnt_busy - b_busy, (4 + 25 + 1 + 128 + 4) * BITCYC);
    chk("p5_err", cnt_err - b_err, 0);
    sb_check("p5", 64);
    chk("p5_ovr", OVERRUN, 1'b0);

    // Consumer stalled for a whole page: first byte held, overrun sticks.
    din_mode = 2;
    sb_en = 1'b0;
    RD_READY = 1'b0;
    send(1'b0, 12'd0, 1'b1);
    wait_idle(3000);
    @(negedge MCLK);
    chk("ovr_valid", RD_VALID, 1'b1);
    chk("ovr_data", RD_DATA, 8'h10);
    chk("ovr_flag", OVERRUN, 1'b1);
    tick();
    RD_READY = 1'b1;
    tick();
    RD_READY = 1'b0;
    @(negedge MCLK);
    chk("ovr_drain", RD_VALID, 1'b0);
    tick();
    @(negedge MCLK);
    chk("ovr_sticky", OVERRUN, 1'b1);
    RD_READY = 1'b1;
    sb_en = 1'b1;

    // Abort in XFER at slot 100 of a 1-bit page 0 read.
    din_mode = 0;
    tick();
    snap();
    send(1'b0, 12'd0, 1'b0);
    n = 0;
    while (!(xact && xslot == 100 && xcyc == 0) && n < 5000) begin
      @(posedge MCLK);
      #2;
      n++;
    end
    chk("abx_timeout", (n < 5000), 1);
    ABORT = 1'b1;
    @(posedge MCLK);
    #1;
    ABORT = 1'b0;
    @(negedge MCLK);
    chk("abx_ctl", ctl_now(), 5'h1F);
    chk("abx_busy", BUSY, 1'b1);
    wait_idle(200);
    chk("abx_bsen", cnt_bsen - b_bsen, (20 + 1) * BITCYC + 100 * BITCYC + 1);
    chk("abx_busy_cnt", cnt_busy - b_busy, (4 + 20 + 1 + 4) * BITCYC + 100 * BITCYC + 1);
    sb_check("abx", 12);

    // Reset asserted during SEEK, then a normal read.
    din_mode = 2;
    send(1'b0, 12'd3, 1'b1);
    n = 0;
    while (!(nBSS && !nBSEN) && n < 200) begin
      tick();
      n++;
    end
    chk("rs_seek_timeout", (n < 200), 1);
    repeat (5) tick();
    nRESET = 1'b0;
    #2;
    chk_reset_vals("rs_async");
    repeat (2) tick();
    nRESET = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    snap();
    send(1'b0, 12'd1, 1'b1);
    wait_idle(3000);
    chk("rs_bsen", cnt_bsen - b_bsen, (21 + 1 + 128) * BITCYC);
    chk("rs_busy", cnt_busy - b_busy, (4 + 21 + 1 + 128 + 4) * BITCYC);
    chk("rs_ovr", OVERRUN, 1'b0);
    sb_check("rs", 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bubble_page_reader.md
Name: bubble_page_reader

Overview:
Host-side read initiator for the bubble emulation core. It accepts a read command (bootloop or page N), drives nBSS/nBSEN/nREPEN/nBOOTEN/nSWAPEN with bit-slot timing, samples the emulator's DOUT lines, and delivers the data as bytes. It is used as a bench stimulus/checker and as the read engine of a future controller.

Parameters:
BITCYC, 480, MCLK cycles per bubble bit-slot.
SAMPLEOFS, 240, slot cycle index at which DIN is sampled (0..BITCYC-1).
STARTSLOTS, 4, slots nBSS is held low.
SEEKOFS, 20, fixed seek slots before page 0.
PAGEBITS, 512, data bits per page; multiple of 8.
NPAGES, 2053, number of valid user pages.
STOPSLOTS, 4, idle slots after transfer.

Ports:
MCLK  in  1  48 MHz clock
nRESET  in  1  reset, asynchronous, active-low
CMD_VALID  in  1  command request
CMD_READY  out  1  high in IDLE only
CMD_BOOT  in  1  1 = bootloop read, page ignored
CMD_PAGE  in  12  target user page
BITWIDTH4  in  1  1 = sample DIN[3:0] per slot; 0 = DIN[0] only; latched at command accept
ABORT  in  1  synchronous abort
DIN  in  4  emulator DOUT3..DOUT0
nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN  out  1 each  bubble control, active-low
RD_DATA  out  8  assembled byte
RD_VALID  out  1  byte available
RD_READY  in  1  consumer accepts byte
BUSY  out  1  not IDLE
CMD_ERR  out  1  one-cycle pulse on rejected command
OVERRUN  out  1  sticky; byte lost

Behaviour:
- Clock MCLK only; reset asynchronous, active-low.
- Reset values: all n* controls 1, CMD_READY 1, BUSY 0, RD_VALID 0, RD_DATA 0, CMD_ERR 0, OVERRUN 0, state IDLE. Reset mid-transfer aborts immediately; no partial byte is emitted.
- nSWAPEN is held 1 at all times (the reader never writes).
- DIN passes through a 2-FF synchronizer; effective sample is DIN at slot cycle SAMPLEOFS-2.
- Slot counter 0..BITCYC-1, cleared on command accept; "slot end" = counter==BITCYC-1; all state changes happen at slot end except accept, reject and abort.
- Accept: CMD_VALID & CMD_READY. If !CMD_BOOT and CMD_PAGE>=NPAGES -> CMD_ERR pulse the next cycle, remain IDLE. Otherwise latch cmd, go START next cycle.
- States and controls:
  IDLE: all controls 1.
  START: nBSS=0 for STARTSLOTS slots -> SEEK.
  SEEK: nBSEN=0 for SEEKOFS+page slots (boot: SEEKOFS) -> REPL. Seek count width 13 bits, no wrap.
  REPL: nBSEN=0, nREPEN=0 for 1 slot -> XFER.
  XFER: nBSEN=0; sample at SAMPLEOFS; PAGEBITS slots (BITWIDTH4: PAGEBITS/4 slots) -> STOP.
  STOP: all controls 1 for STOPSLOTS slots -> IDLE.
  nBOOTEN=0 throughout START..XFER when the command is a boot read.
- Byte assembly: LSB first; 1-bit mode bit k of byte = k-th sample; 4-bit mode first nibble DIN[3:0] -> bits[3:0], second -> bits[7:4]. Byte completes at the sample cycle; RD_VALID rises next cycle.
- Output holding register: RD_VALID stays high until RD_VALID&RD_READY. A byte completing while RD_VALID=1 and not accepted in the same cycle is dropped and OVERRUN sets (cleared only by reset). Simultaneous accept and completion: new byte loaded, no overrun.
- ABORT in START/SEEK/REPL/XFER: next cycle -> STOP, slot counter cleared, partial byte discarded; ABORT in IDLE/STOP ignored.
- CMD_VALID while BUSY is ignored (not queued).

Decomposition:
- Package bubble_pkg: state enum (IDLE, START, SEEK, REPL, XFER, STOP), control bit-vector index constants, default timing constants shared with TimingGenerator tests.
- One sub-module natural: bubble_slot_timer (slot counter, slot_end and sample strobes).

Test Plan:
- Boot read, BITWIDTH4=0, DIN[0] pattern 1,0,1,1,0,0,0,0 repeating -> nBSS low 4*480 cycles, nBOOTEN low START..XFER, 64 bytes of 0x0D, nSWAPEN always 1.
- Page 5 read, BITWIDTH4=1, DIN=0xA then 0x5 alternating -> seek 25 slots, 128 XFER slots, 64 bytes of 0x5A, nBOOTEN stays 1.
- CMD_PAGE=2053 -> CMD_ERR single pulse, BUSY stays 0, controls unchanged.
- RD_READY held 0 for a whole page -> first byte held, OVERRUN=1, RD_DATA unchanged; then RD_READY=1 -> one transfer, RD_VALID drops.
- ABORT mid-XFER at slot 100 -> controls all 1 next cycle, 4 STOP slots, back to IDLE, no extra bytes.
- nRESET asserted during SEEK -> all outputs at reset values asynchronously; a new command after release runs normally.
